// File: rtl/direction_scheduler_if.sv
// Bundle between the key one-shots / step timer and the direction scheduler.
// The master drives pulses and ticks; the slave (scheduler) returns the applied direction and status.
interface direction_scheduler_if #(
  parameter int unsigned QUEUE_DEPTH = 2
);
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

  logic [3:0]       btn_pulse;
  logic             step_tick;
  logic             flush;
  logic [1:0]       dir;
  logic             dir_changed;
  logic             drop;
  logic [CNT_W-1:0] q_count;

  modport master (
    output btn_pulse, step_tick, flush,
    input  dir, dir_changed, drop, q_count
  );

  modport slave (
    input  btn_pulse, step_tick, flush,
    output dir, dir_changed, drop, q_count
  );
endinterface

// File: rtl/direction_scheduler.sv
// Arbitrates key pulses, filters redundant/reverse moves, queues them and applies one per step tick.
// Optional macro DIR_SCHED_RR_EN: rotating-priority arbitration instead of fixed lowest-index priority.
module direction_scheduler #(
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter logic [1:0]  INIT_DIR    = 2'b11
) (
  input  logic                 clock,
  input  logic                 reset,
  direction_scheduler_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  logic [1:0]       fifo_q [QUEUE_DEPTH];
  logic [1:0]       fifo_d [QUEUE_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       dir_q, dir_d;
  logic             dir_changed_q, dir_changed_d;
  logic             drop_q, drop_d;

  logic             grant_valid;
  logic [1:0]       grant_idx;
  logic [1:0]       ref_dir;
  logic [PTR_W-1:0] tail_prev;
  logic             cand_ok;
  logic             pop;
  logic             push;
  logic [3:0]       enq_mask;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef DIR_SCHED_RR_EN
  logic [1:0] rr_q, rr_d;

  // Rotating search starting at rr_q; pointer moves past whichever index won.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (!grant_valid && bus.btn_pulse[2'(int'(rr_q) + k)]) begin
        grant_valid = 1'b1;
        grant_idx   = 2'(int'(rr_q) + k);
      end
    end
    rr_d = rr_q;
    if (bus.flush)        rr_d = 2'b00;
    else if (grant_valid) rr_d = grant_idx + 2'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) rr_q <= 2'b00;
    else       rr_q <= rr_d;
  end
`else
  // Fixed priority: lowest direction code wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (!grant_valid && bus.btn_pulse[k]) begin
        grant_valid = 1'b1;
        grant_idx   = 2'(k);
      end
    end
  end
`endif

  // Filter, push/pop decisions and next-state.
  always_comb begin
    fifo_d        = fifo_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    dir_d         = dir_q;
    dir_changed_d = 1'b0;
    drop_d        = 1'b0;

    tail_prev = (tail_q == '0) ? PTR_W'(QUEUE_DEPTH - 1) : tail_q - PTR_W'(1);
    ref_dir   = (count_q != '0) ? fifo_q[tail_prev] : dir_q;
    cand_ok   = grant_valid && (grant_idx != ref_dir) && (grant_idx != (ref_dir ^ 2'b01));
    pop       = bus.step_tick && (count_q != '0);
    push      = cand_ok && ((count_q < CNT_W'(QUEUE_DEPTH)) || pop);
    enq_mask  = push ? (4'b0001 << grant_idx) : 4'b0000;

    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      dir_d   = INIT_DIR;
    end else begin
      drop_d = |(bus.btn_pulse & ~enq_mask);
      if (pop) begin
        dir_d         = fifo_q[head_q];
        dir_changed_d = 1'b1;
        head_d        = ptr_inc(head_q);
      end
      if (push) begin
        fifo_d[tail_q] = grant_idx;
        tail_d         = ptr_inc(tail_q);
      end
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) fifo_q[i] <= 2'b00;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      dir_q         <= INIT_DIR;
      dir_changed_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      fifo_q        <= fifo_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      dir_q         <= dir_d;
      dir_changed_q <= dir_changed_d;
      drop_q        <= drop_d;
    end
  end

  assign bus.dir         = dir_q;
  assign bus.dir_changed = dir_changed_q;
  assign bus.drop        = drop_q;
  assign bus.q_count     = count_q;
endmodule

// File: tb/tb_direction_scheduler.sv
// Randomized bench for direction_scheduler against a queue-based reference model, plus directed scenarios.
// Honours DIR_SCHED_RR_EN the same way the design does.
module tb_direction_scheduler;
  localparam int unsigned DEPTH = 2;
  localparam logic [1:0]  INIT  = 2'b11;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  direction_scheduler_if #(.QUEUE_DEPTH(DEPTH)) bus ();

  direction_scheduler #(.QUEUE_DEPTH(DEPTH), .INIT_DIR(INIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [1:0] m_q[$];
  logic [1:0] m_dir     = INIT;
  logic       m_changed = 1'b0;
  logic       m_drop    = 1'b0;
  int         m_rr      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic [3:0] btn, input logic tick, input logic fl);
    int         g;
    logic [1:0] r;
    bit         ok, pop, push;
    m_changed = 1'b0;
    m_drop    = 1'b0;
    if (rst || fl) begin
      m_q.delete();
      m_dir = INIT;
      m_rr  = 0;
      return;
    end
    g = -1;
`ifdef DIR_SCHED_RR_EN
    for (int k = 0; k < 4; k++)
      if (g < 0 && btn[(m_rr + k) % 4]) g = (m_rr + k) % 4;
    if (g >= 0) m_rr = (g + 1) % 4;
`else
    for (int k = 0; k < 4; k++)
      if (g < 0 && btn[k]) g = k;
`endif
    r    = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
    ok   = (g >= 0) && (2'(g) != r) && (2'(g) != (r ^ 2'b01));
    pop  = tick && (m_q.size() > 0);
    push = ok && ((m_q.size() < DEPTH) || pop);
    if (pop) begin
      m_dir     = m_q.pop_front();
      m_changed = 1'b1;
    end
    if (push) m_q.push_back(2'(g));
    for (int k = 0; k < 4; k++)
      if (btn[k] && !(push && k == g)) m_drop = 1'b1;
  endtask

  // One clock: drive inputs, advance the model, then compare every output after the edge.
  task automatic do_cycle(input logic rst, input logic [3:0] btn, input logic tick, input logic fl);
    reset         = rst;
    bus.btn_pulse = btn;
    bus.step_tick = tick;
    bus.flush     = fl;
    model_step(rst, btn, tick, fl);
    @(posedge clock);
    #1;
    check("dir",         32'(bus.dir),         32'(m_dir));
    check("dir_changed", 32'(bus.dir_changed), 32'(m_changed));
    check("drop",        32'(bus.drop),        32'(m_drop));
    check("q_count",     32'(bus.q_count),     32'(m_q.size()));
  endtask

  initial begin
    logic [3:0] b;
    logic       t, f, r;
    bus.btn_pulse = 4'b0;
    bus.step_tick = 1'b0;
    bus.flush     = 1'b0;

    do_cycle(1, 4'b0, 0, 0);
    do_cycle(1, 4'b0, 0, 0);
    check("rst_dir", 32'(bus.dir), 32'd3);
    check("rst_q",   32'(bus.q_count), 32'd0);

    // Idle ticks on an empty queue
    for (int i = 0; i < 5; i++) begin
      do_cycle(0, 4'b0, 1, 0);
      check("idle_changed", 32'(bus.dir_changed), 32'd0);
    end
    check("idle_dir", 32'(bus.dir), 32'd3);

    // UP accepted, applied on a later tick for exactly one cycle
    do_cycle(0, 4'b0001, 0, 0);
    check("up_q", 32'(bus.q_count), 32'd1);
    check("up_drop", 32'(bus.drop), 32'd0);
    do_cycle(0, 4'b0, 0, 0);
    do_cycle(0, 4'b0, 0, 0);
    do_cycle(0, 4'b0, 1, 0);
    check("up_dir", 32'(bus.dir), 32'd0);
    check("up_changed", 32'(bus.dir_changed), 32'd1);
    do_cycle(0, 4'b0, 0, 0);
    check("up_changed_off", 32'(bus.dir_changed), 32'd0);

    // Reverse and equal moves are dropped
    do_cycle(0, 4'b0, 0, 1);
    check("flush_dir", 32'(bus.dir), 32'd3);
    do_cycle(0, 4'b0100, 0, 0);
    check("rev_drop", 32'(bus.drop), 32'd1);
    check("rev_q", 32'(bus.q_count), 32'd0);
    do_cycle(0, 4'b1000, 0, 0);
    check("eq_drop", 32'(bus.drop), 32'd1);
    check("eq_q", 32'(bus.q_count), 32'd0);

    // Fill the queue, third pulse hits full
    do_cycle(0, 4'b0001, 0, 0);
    do_cycle(0, 4'b0100, 0, 0);
    do_cycle(0, 4'b0010, 0, 0);
    check("full_drop", 32'(bus.drop), 32'd1);
    check("full_q", 32'(bus.q_count), 32'd2);
    do_cycle(0, 4'b0, 1, 0);
    check("full_dir1", 32'(bus.dir), 32'd0);
    do_cycle(0, 4'b0, 1, 0);
    check("full_dir2", 32'(bus.dir), 32'd2);

    // Simultaneous UP+LEFT arbitration
    do_cycle(0, 4'b0, 0, 1);
    do_cycle(0, 4'b0101, 0, 0);
    check("arb1_drop", 32'(bus.drop), 32'd1);
    check("arb1_q", 32'(bus.q_count), 32'd1);
    do_cycle(0, 4'b0, 1, 0);
    check("arb1_dir", 32'(bus.dir), 32'd0);
    do_cycle(0, 4'b0101, 0, 0);
`ifdef DIR_SCHED_RR_EN
    check("arb2_q", 32'(bus.q_count), 32'd1);
    do_cycle(0, 4'b0, 1, 0);
    check("arb2_dir", 32'(bus.dir), 32'd2);
`else
    check("arb2_q", 32'(bus.q_count), 32'd0);
`endif

    // Flush with tick and pulse on a full queue
    do_cycle(0, 4'b0, 0, 1);
    do_cycle(0, 4'b0001, 0, 0);
    do_cycle(0, 4'b0100, 0, 0);
    check("pre_flush_q", 32'(bus.q_count), 32'd2);
    do_cycle(0, 4'b0010, 1, 1);
    check("fl_dir", 32'(bus.dir), 32'd3);
    check("fl_q", 32'(bus.q_count), 32'd0);
    check("fl_changed", 32'(bus.dir_changed), 32'd0);
    check("fl_drop", 32'(bus.drop), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      b = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) b = 4'b0;
      t = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 60) == 0);
      r = ($urandom_range(0, 250) == 0);
      do_cycle(r, b, t, f);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
